// File: rtl/thermo_decoder_if.sv
// Thermometer decoder bus: the sample side (thermometer code, complement rail
// and qualifier) plus the decoded result side (binary value, valid, flags).
// The master drives samples; the slave (the decoder) drives results.
interface thermo_decoder_if #(
  parameter int N_BITS = 8
);
  localparam int T = (1 << N_BITS) - 1;

  logic              thermo_in   [T:1];
  logic              thermo_in_b [T:1];
  logic              sample_valid;
  logic [N_BITS-1:0] binary_out;
  logic              out_valid;
  logic              rail_error;
  logic              bubble_flag;

  modport master (
    output thermo_in, thermo_in_b, sample_valid,
    input  binary_out, out_valid, rail_error, bubble_flag
  );

  modport slave (
    input  thermo_in, thermo_in_b, sample_valid,
    output binary_out, out_valid, rail_error, bubble_flag
  );
endinterface

// File: rtl/thermo_decoder.sv
// Thermometer-to-binary decoder, 3-stage pipeline:
//   stage 0 captures the code and its complement rail,
//   stage 1 derives the rail/bubble flags and per-group popcounts,
//   stage 2 sums the groups and registers the result.
// Optional feature macro: THERMO_BUBBLE_CORRECT_EN. When defined, each code bit
// is replaced by the 3-input majority of itself and its neighbours before the
// count, so a single isolated bubble decodes to the intended level. Flags are
// always taken from the uncorrected capture.
module thermo_decoder #(
  parameter int N_BITS = 8,
  parameter int GROUP  = 16
) (
  input  logic              clk,
  input  logic              rst,
  thermo_decoder_if.slave   bus
);
  localparam int T  = (1 << N_BITS) - 1;
  localparam int NG = (T + 1) / GROUP;
  localparam int CW = $clog2(GROUP + 1);

  // ---------------- stage 0: capture ----------------
  logic [T:1]   t0_reg;
  logic [T-1:1] tb0_reg;
  logic         v0_reg;

  // Capture a qualified sample; data holds when nothing is offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t0_reg  <= '0;
      tb0_reg <= '0;
      v0_reg  <= 1'b0;
    end else begin
      v0_reg <= bus.sample_valid;
      if (bus.sample_valid) begin
        for (int i = 1; i <= T; i++) begin
          t0_reg[i] <= bus.thermo_in[i];
        end
        for (int i = 1; i <= T - 1; i++) begin
          tb0_reg[i] <= bus.thermo_in_b[i];
        end
      end
    end
  end

  // ---------------- stage 1: flags, correction, partial counts ----------------
  logic [T-1:1] rail_bits;
  logic [T-1:1] bub_bits;
  logic [T:0]   code_pad;

  // Flags only look at positions 1..T-1 (the adjacent-pair range).
  genvar gi;
  generate
    for (gi = 1; gi <= T - 1; gi++) begin : g_flag
      assign rail_bits[gi] = t0_reg[gi] ~^ tb0_reg[gi];
      assign bub_bits[gi]  = ~t0_reg[gi] & t0_reg[gi+1];
    end
  endgenerate

  // Position 0 pads the first count group so every group is GROUP wide.
  assign code_pad[0] = 1'b0;

`ifdef THERMO_BUBBLE_CORRECT_EN
  // Below level 1 the code is implicitly 1, above level T it is implicitly 0.
  logic [T+1:0] ext;
  assign ext = {1'b0, t0_reg, 1'b1};
  generate
    for (gi = 1; gi <= T; gi++) begin : g_maj
      assign code_pad[gi] = (ext[gi-1] & ext[gi]) |
                            (ext[gi-1] & ext[gi+1]) |
                            (ext[gi]   & ext[gi+1]);
    end
  endgenerate
`else
  assign code_pad[T:1] = t0_reg;
`endif

  logic [CW-1:0] grp_cnt [NG];

  // Popcount of each GROUP-wide slice of the (padded) code.
  always_comb begin
    for (int g = 0; g < NG; g++) begin
      grp_cnt[g] = '0;
      for (int b = 0; b < GROUP; b++) begin
        grp_cnt[g] = grp_cnt[g] + CW'(code_pad[g*GROUP + b]);
      end
    end
  end

  logic [CW-1:0] cnt_reg [NG];
  logic          rail1_reg;
  logic          bub1_reg;
  logic          v1_reg;

  // Register partial counts and flags for a valid stage-0 sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < NG; g++) begin
        cnt_reg[g] <= '0;
      end
      rail1_reg <= 1'b0;
      bub1_reg  <= 1'b0;
      v1_reg    <= 1'b0;
    end else begin
      v1_reg <= v0_reg;
      if (v0_reg) begin
        cnt_reg   <= grp_cnt;
        rail1_reg <= |rail_bits;
        bub1_reg  <= |bub_bits;
      end
    end
  end

  // ---------------- stage 2: sum and output ----------------
  logic [N_BITS-1:0] sum;

  // Total never exceeds T, so N_BITS holds it without saturation.
  always_comb begin
    sum = '0;
    for (int g = 0; g < NG; g++) begin
      sum = sum + N_BITS'(cnt_reg[g]);
    end
  end

  logic [N_BITS-1:0] bin_reg;
  logic              out_valid_reg;
  logic              rail_reg;
  logic              bub_reg;

  // Outputs update only on a valid result and otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_reg       <= '0;
      out_valid_reg <= 1'b0;
      rail_reg      <= 1'b0;
      bub_reg       <= 1'b0;
    end else begin
      out_valid_reg <= v1_reg;
      if (v1_reg) begin
        bin_reg  <= sum;
        rail_reg <= rail1_reg;
        bub_reg  <= bub1_reg;
      end
    end
  end

  assign bus.binary_out  = bin_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.rail_error  = rail_reg;
  assign bus.bubble_flag = bub_reg;
endmodule

// File: tb/tb_thermo_decoder.sv
// Bench for thermo_decoder: a scoreboard of expected results (value = ones
// count, flags from the raw capture) due three cycles after each sample, a
// per-cycle compare process, and directed literal checks for named cases.
module tb_thermo_decoder;
  localparam int N_BITS = 8;
  localparam int T      = (1 << N_BITS) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  thermo_decoder_if #(.N_BITS(N_BITS)) bus ();

  thermo_decoder #(.N_BITS(N_BITS), .GROUP(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int due;
    int val;
    bit rail;
    bit bub;
  } exp_t;

  exp_t q[$];
  exp_t ce;
  int   held_bin  = 0;
  int   held_rail = 0;
  int   held_bub  = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rules: value is the ones count of the (optionally majority-
  // corrected) code; flags come from the raw code over positions 1..T-1.
  function automatic void model(input bit [T:1] tv, input bit [T:1] tbv,
                                output int val, output bit rail, output bit bub);
    int lo, hi, votes;
    val  = 0;
    rail = 1'b0;
    bub  = 1'b0;
    for (int i = 1; i <= T; i++) begin
`ifdef THERMO_BUBBLE_CORRECT_EN
      lo    = (i == 1) ? 1 : int'(tv[i-1]);
      hi    = (i == T) ? 0 : int'(tv[i+1]);
      votes = lo + int'(tv[i]) + hi;
      if (votes >= 2) val++;
`else
      lo = 0; hi = 0; votes = 0;
      if (tv[i]) val++;
`endif
    end
    for (int i = 1; i <= T - 1; i++) begin
      if (tv[i] == tbv[i]) rail = 1'b1;
      if (!tv[i] && tv[i+1]) bub = 1'b1;
    end
  endfunction

  function automatic bit [T:1] therm(input int v);
    bit [T:1] r;
    for (int i = 1; i <= T; i++) r[i] = (i <= v);
    return r;
  endfunction

  task automatic drive(input bit [T:1] tv, input bit [T:1] tbv);
    exp_t e;
    @(negedge clk);
    for (int i = 1; i <= T; i++) begin
      bus.thermo_in[i]   = tv[i];
      bus.thermo_in_b[i] = tbv[i];
    end
    bus.sample_valid = 1'b1;
    model(tv, tbv, e.val, e.rail, e.bub);
    e.due = cyc + 3;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic lit(input string name, input int bin, input int rail, input int bub);
    #1;
    cmp({name, "_valid"}, int'(bus.out_valid), 1);
    cmp({name, "_bin"},   int'(bus.binary_out), bin);
    cmp({name, "_rail"},  int'(bus.rail_error), rail);
    cmp({name, "_bub"},   int'(bus.bubble_flag), bub);
  endtask

  // Reset flushes every in-flight sample and zeroes the held outputs.
  always @(negedge rst) begin
    q.delete();
    held_bin  = 0;
    held_rail = 0;
    held_bub  = 0;
  end

  // Per-cycle compare against the scoreboard, sampled after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      cmp("rst_valid", int'(bus.out_valid), 0);
      cmp("rst_bin",   int'(bus.binary_out), 0);
      cmp("rst_rail",  int'(bus.rail_error), 0);
      cmp("rst_bub",   int'(bus.bubble_flag), 0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      ce = q.pop_front();
      cmp("sb_valid", int'(bus.out_valid), 1);
      cmp("sb_bin",   int'(bus.binary_out), ce.val);
      cmp("sb_rail",  int'(bus.rail_error), int'(ce.rail));
      cmp("sb_bub",   int'(bus.bubble_flag), int'(ce.bub));
      held_bin  = ce.val;
      held_rail = int'(ce.rail);
      held_bub  = int'(ce.bub);
      $display("[TB] cycle %0d out value=%0d rail=%0d bubble=%0d", cyc,
               int'(bus.binary_out), int'(bus.rail_error), int'(bus.bubble_flag));
    end else begin
      cmp("sb_idle_valid", int'(bus.out_valid), 0);
      cmp("sb_hold_bin",   int'(bus.binary_out), held_bin);
      cmp("sb_hold_rail",  int'(bus.rail_error), held_rail);
      cmp("sb_hold_bub",   int'(bus.bubble_flag), held_bub);
    end
  end

  initial begin
    bit [T:1] a;
    bit [T:1] b;
    bus.sample_valid = 1'b0;
    for (int i = 1; i <= T; i++) begin
      bus.thermo_in[i]   = 1'b0;
      bus.thermo_in_b[i] = 1'b1;
    end

    // Reset held for three cycles, then idle.
    repeat (3) @(negedge clk);
    #1;
    cmp("reset_valid", int'(bus.out_valid), 0);
    cmp("reset_bin",   int'(bus.binary_out), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) idle();

    // Back-to-back sweep of every level.
    for (int v = 0; v <= T; v++) drive(therm(v), ~therm(v));
    repeat (4) idle();
    #1;
    cmp("sweep_hold_bin", int'(bus.binary_out), 255);

    // Single bubble at position 50 of level 100.
    a = therm(100);
    a[50] = 1'b0;
    drive(a, ~a);
    repeat (3) idle();
`ifdef THERMO_BUBBLE_CORRECT_EN
    lit("bubble", 100, 0, 1);
`else
    lit("bubble", 99, 0, 1);
`endif

    // Rail fault at bit 20 on level 37, then a clean sample clears it.
    a = therm(37);
    b = ~a;
    b[20] = a[20];
    drive(a, b);
    drive(therm(38), ~therm(38));
    repeat (2) idle();
    lit("rail", 37, 1, 0);
    idle();
    lit("rail_clear", 38, 0, 0);

    // Gapped valid: 5, gap, 200, gap, gap, 255.
    drive(therm(5), ~therm(5));
    idle();
    drive(therm(200), ~therm(200));
    idle();
    lit("gap_5", 5, 0, 0);
    idle();
    #1;
    cmp("gap_hold_valid", int'(bus.out_valid), 0);
    cmp("gap_hold_bin",   int'(bus.binary_out), 5);
    drive(therm(255), ~therm(255));
    lit("gap_200", 200, 0, 0);
    repeat (3) idle();
    lit("gap_255", 255, 0, 0);

    // Mid-flight reset: three samples, reset before the first can emerge.
    drive(therm(10), ~therm(10));
    drive(therm(20), ~therm(20));
    drive(therm(30), ~therm(30));
    #3;
    rst = 1'b0;
    idle();
    rst = 1'b1;
    repeat (5) idle();
    #1;
    cmp("flush_valid", int'(bus.out_valid), 0);
    cmp("flush_bin",   int'(bus.binary_out), 0);

    repeat (2) idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
